// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_lsu
// Brief    : Memory stage with req/ack data port, load extension and timeout.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage_lsu #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] store_data_in,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall,
    output logic        valid_out,
    output logic [31:0] result_out,
    output logic        misaligned,
    output logic        bus_err
);

    localparam int              c_CW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CW-1:0] c_TMAX = c_CW'(TIMEOUT_CYCLES - 1);
    localparam logic [0:0]      c_IDLE = 1'b0;
    localparam logic [0:0]      c_WAIT = 1'b1;

    logic [0:0]      r_state, w_next;
    logic [c_CW-1:0] r_cnt;
    logic            r_req, r_we, r_valid_out, r_mis, r_berr;
    logic [31:0]     r_addr, r_wdata, r_alu, r_result;
    logic [3:0]      r_be;
    logic [2:0]      r_f3;
    logic [1:0]      r_lane;

    logic        w_memop, w_f3_ok, w_align_ok, w_start, w_bad;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_load_data;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_memop = valid_in & (mem_read | mem_write);
    assign w_f3_ok = (funct3 != 3'b011) & (funct3[2:1] != 2'b11);

    always_comb begin
        case (funct3[1:0])
            2'b00:   w_align_ok = 1'b1;
            2'b01:   w_align_ok = ~alu_result_in[0];
            2'b10:   w_align_ok = (alu_result_in[1:0] == 2'b00);
            default: w_align_ok = 1'b0;
        endcase
    end

    assign w_start = (r_state == c_IDLE) & w_memop & w_f3_ok & w_align_ok;
    assign w_bad   = w_memop & ~(w_f3_ok & w_align_ok);

    // Byte/half stores are lane-replicated so memory picks data by byte enable.
    always_comb begin
        w_be    = 4'hF;
        w_wdata = '0;
        if (!mem_read) begin
            w_wdata = store_data_in;
            case (funct3[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << alu_result_in[1:0];
                    w_wdata = {4{store_data_in[7:0]}};
                end
                2'b01: begin
                    w_be    = 4'b0011 << alu_result_in[1:0];
                    w_wdata = {2{store_data_in[15:0]}};
                end
                default: ;
            endcase
        end
    end

    assign w_byte = dmem_rdata[{r_lane, 3'b000} +: 8];
    assign w_half = r_lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        case (r_f3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_data = {24'd0, w_byte};
            3'b101:  w_load_data = {16'd0, w_half};
            default: w_load_data = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:  if (w_start) w_next = c_WAIT;
            c_WAIT:  if (dmem_ack || r_cnt == c_TMAX) w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    always_comb begin
        stall = (r_state == c_WAIT) | w_start;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_be        <= '0;
            r_wdata     <= '0;
            r_f3        <= '0;
            r_lane      <= '0;
            r_alu       <= '0;
            r_cnt       <= '0;
            r_valid_out <= 1'b0;
            r_result    <= '0;
            r_mis       <= 1'b0;
            r_berr      <= 1'b0;
        end else begin
            r_valid_out <= 1'b0;
            r_mis       <= 1'b0;
            r_berr      <= 1'b0;
            if (r_state == c_IDLE) begin
                if (w_start) begin
                    r_req   <= 1'b1;
                    r_we    <= ~mem_read;
                    r_addr  <= {alu_result_in[31:2], 2'b00};
                    r_be    <= w_be;
                    r_wdata <= w_wdata;
                    r_f3    <= funct3;
                    r_lane  <= alu_result_in[1:0];
                    r_alu   <= alu_result_in;
                    r_cnt   <= '0;
                end else if (valid_in) begin
                    r_valid_out <= 1'b1;
                    r_mis       <= w_bad;
                    r_result    <= w_bad ? 32'd0 : alu_result_in;
                end
            end else if (dmem_ack) begin
                r_req       <= 1'b0;
                r_valid_out <= 1'b1;
                r_result    <= r_we ? r_alu : w_load_data;
            end else if (r_cnt == c_TMAX) begin
                r_req       <= 1'b0;
                r_valid_out <= 1'b1;
                r_berr      <= 1'b1;
                r_result    <= '0;
            end else begin
                r_cnt <= r_cnt + c_CW'(1);
            end
        end
    end

    assign dmem_req   = r_req;
    assign dmem_we    = r_we;
    assign dmem_addr  = r_addr;
    assign dmem_be    = r_be;
    assign dmem_wdata = r_wdata;
    assign valid_out  = r_valid_out;
    assign result_out = r_result;
    assign misaligned = r_mis;
    assign bus_err    = r_berr;

endmodule
`default_nettype wire
